// File: rtl/chess_pkg.sv
// Shared chess-engine types used by the move-search datapath.
//   square_t        : 6-bit square number, {rank, file}
//   NUM_SQUARES     : board size
//   arb_seq_state_t : state encoding for arb_sequencer
package chess_pkg;

    localparam int NUM_SQUARES = 64;

    typedef logic [5:0] square_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OFFER  = 2'd2,
        DONE   = 2'd3
    } arb_seq_state_t;

endpackage

// File: rtl/arb_sequencer.sv
// arb_sequencer: walks the external square arbiter through every square with
// nonzero priority, highest priority first, by emitting the current winner on a
// valid/ready stream and then masking it out so the arbiter moves on.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin a new enumeration (honoured only when idle)
//   abort          drop back to idle from any state
//   arb_sq         current arbiter winner {rank, file}
//   arb_none       arbiter sees no nonzero priority
//   mask           per-square "already emitted" bits, fed back to the arbiter
//   out_valid      out_sq/out_idx are being offered
//   out_ready      downstream accepts
//   out_sq         emitted square
//   out_idx        ordinal of out_sq within this enumeration
//   busy           high whenever not idle
//   done           one-cycle pulse at end of enumeration
//   limit          (ARB_SEQ_LIMIT_EN only) maximum emissions, 0 = unlimited
//
// Build option: define ARB_SEQ_LIMIT_EN to add the limit input.
//
// state  | meaning
// IDLE   | waiting for start; mask holds its last value
// SETTLE | counting down while the arbiter settles on the new mask
// OFFER  | out_sq offered until out_ready
// DONE   | one-cycle done pulse, then IDLE
module arb_sequencer
    import chess_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  square_t                arb_sq,
    input  logic                   arb_none,
    output logic [NUM_SQUARES-1:0] mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output square_t                out_sq,
    output logic [6:0]             out_idx,
    output logic                   busy,
    output logic                   done
`ifdef ARB_SEQ_LIMIT_EN
    ,
    input  logic [6:0]             limit
`endif
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    arb_seq_state_t         state_q, state_d;
    logic [NUM_SQUARES-1:0] mask_q, mask_d;
    logic                   out_valid_q, out_valid_d;
    square_t                out_sq_q, out_sq_d;
    logic [6:0]             out_idx_q, out_idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   limit_hit;

`ifdef ARB_SEQ_LIMIT_EN
    logic [6:0] limit_q, limit_d;

    assign limit_hit = (limit_q != 7'd0) && (out_idx_q == limit_q);
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_sq_d    = out_sq_q;
        out_idx_d   = out_idx_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
`ifdef ARB_SEQ_LIMIT_EN
        limit_d     = limit_q;
`endif

        if (abort) begin
            // Also covers abort+start in IDLE: start is simply not looked at.
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_d    = '0;
                        out_idx_d = 7'd0;
                        cnt_d     = SETTLE_LOAD;
                        state_d   = SETTLE;
`ifdef ARB_SEQ_LIMIT_EN
                        limit_d   = limit;
`endif
                    end
                end
                SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (limit_hit || arb_none) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // A winner whose mask bit is already set is emitted
                        // anyway; re-setting the bit is harmless.
                        out_sq_d       = arb_sq;
                        mask_d[arb_sq] = 1'b1;
                        out_valid_d    = 1'b1;
                        state_d        = OFFER;
                    end
                end
                OFFER: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        out_idx_d   = out_idx_q + 7'd1;
                        cnt_d       = SETTLE_LOAD;
                        state_d     = SETTLE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_sq_q    <= '0;
            out_idx_q   <= 7'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 4'd0;
`ifdef ARB_SEQ_LIMIT_EN
            limit_q     <= 7'd0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_sq_q    <= out_sq_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
`ifdef ARB_SEQ_LIMIT_EN
            limit_q     <= limit_d;
`endif
        end
    end

    assign mask      = mask_q;
    assign out_valid = out_valid_q;
    assign out_sq    = out_sq_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_arb_sequencer.sv
// Directed bench for arb_sequencer (SETTLE_CYCLES = 2) with a behavioural
// model of the upstream priority arbiter closing the mask loop.
module tb_arb_sequencer;
    import chess_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   abort;
    square_t                arb_sq;
    logic                   arb_none;
    logic [NUM_SQUARES-1:0] mask;
    logic                   out_valid;
    logic                   out_ready;
    square_t                out_sq;
    logic [6:0]             out_idx;
    logic                   busy;
    logic                   done;
`ifdef ARB_SEQ_LIMIT_EN
    logic [6:0]             limit;
`endif

    logic [2:0] prio [NUM_SQUARES];

    int n_checks = 0;
    int n_errors = 0;
    int got_sq[$];
    int got_idx[$];
    int done_cnt;

    arb_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .arb_sq    (arb_sq),
        .arb_none  (arb_none),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sq    (out_sq),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
`ifdef ARB_SEQ_LIMIT_EN
        ,
        .limit     (limit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream arbiter: masked squares forced to priority 0, highest priority
    // wins, ties to the highest index.
    always_comb begin
        logic [2:0] p;
        logic [2:0] best;
        arb_none = 1'b1;
        arb_sq   = '0;
        best     = 3'd0;
        p        = 3'd0;
        for (int n = 0; n < NUM_SQUARES; n++) begin
            p = mask[n] ? 3'd0 : prio[n];
            if (p != 3'd0 && p >= best) begin
                best     = p;
                arb_sq   = 6'(n);
                arb_none = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_prio();
        for (int n = 0; n < NUM_SQUARES; n++) prio[n] = 3'd0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records every accepted beat until done pulses or the budget runs out.
    task automatic run_enum(input string tag, input int max_cycles);
        int cyc;
        got_sq.delete();
        got_idx.delete();
        done_cnt = 0;
        cyc = 0;
        while (cyc < max_cycles && done_cnt == 0) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready) begin
                got_sq.push_back(int'(out_sq));
                got_idx.push_back(int'(out_idx));
            end
            if (done) done_cnt++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
        @(negedge clk);
        check({tag, "_done_pulse_len"}, 64'(done), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic check_list(input string tag, input int exp_sq[$]);
        check({tag, "_count"}, 64'(got_sq.size()), 64'(exp_sq.size()));
        for (int i = 0; i < exp_sq.size() && i < got_sq.size(); i++) begin
            check($sformatf("%s_sq%0d", tag, i), 64'(got_sq[i]), 64'(exp_sq[i]));
            check($sformatf("%s_idx%0d", tag, i), 64'(got_idx[i]), 64'(i));
        end
    endtask

    initial begin
        int k;
        int exp_q[$];
        logic seen;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
`ifdef ARB_SEQ_LIMIT_EN
        limit = 7'd0;
`endif
        clear_prio();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mask", mask, 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_sq", 64'(out_sq), 64'd0);

        // All priorities zero: done 3 cycles after the start cycle.
        pulse_start();
        check("t1_busy_c1", 64'(busy), 64'd1);
        check("t1_done_c1", 64'(done), 64'd0);
        @(negedge clk);
        check("t1_done_c2", 64'(done), 64'd0);
        @(negedge clk);
        check("t1_done_c3", 64'(done), 64'd1);
        check("t1_valid_c3", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_done_c4", 64'(done), 64'd0);
        check("t1_busy_c4", 64'(busy), 64'd0);
        check("t1_mask", mask, 64'd0);

        // Ties at priority 5 go to the higher index.
        clear_prio();
        prio[9] = 3'd3;
        prio[40] = 3'd5;
        prio[12] = 3'd5;
        out_ready = 1'b1;
        pulse_start();
        run_enum("t2", 60);
        exp_q = '{40, 12, 9};
        check_list("t2", exp_q);
        check("t2_mask", mask, (64'd1 << 9) | (64'd1 << 12) | (64'd1 << 40));

        // Back-pressure on a single square; start while busy is ignored.
        clear_prio();
        prio[63] = 3'd1;
        out_ready = 1'b0;
        pulse_start();
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t3_first_valid_lat", 64'(k), 64'd2);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("t3_hold_valid%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("t3_hold_sq%0d", i), 64'(out_sq), 64'd63);
        end
        check("t3_hold_idx", 64'(out_idx), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_accept_valid", 64'(out_valid), 64'd0);
        check("t3_accept_idx", 64'(out_idx), 64'd1);
        run_enum("t3", 20);
        check("t3_no_more", 64'(got_sq.size()), 64'd0);
        check("t3_mask", mask, 64'd1 << 63);

        // Exhaustion: every square at priority 1.
        for (int n = 0; n < NUM_SQUARES; n++) prio[n] = 3'd1;
        out_ready = 1'b1;
        pulse_start();
        run_enum("t4", 400);
        exp_q.delete();
        for (int n = 63; n >= 0; n--) exp_q.push_back(n);
        check_list("t4", exp_q);
        check("t4_mask", mask, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t4_final_idx", 64'(out_idx), 64'd64);

        // Abort while offering the second square.
        clear_prio();
        prio[3] = 3'd2;
        prio[20] = 3'd4;
        prio[50] = 3'd1;
        out_ready = 1'b0;
        pulse_start();
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_first_sq", 64'(out_sq), 64'd20);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_hs_valid_low", 64'(out_valid), 64'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_hs_lat", 64'(k), 64'd2);
        check("t5_second_sq", 64'(out_sq), 64'd3);
        check("t5_second_idx", 64'(out_idx), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_valid", 64'(out_valid), 64'd0);
        check("t5_abort_busy", 64'(busy), 64'd0);
        check("t5_abort_mask", mask, (64'd1 << 3) | (64'd1 << 20));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("t5_no_done_after_abort", 64'(seen), 64'd0);

        // abort and start together in IDLE: start is dropped.
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("t6_abort_start_busy", 64'(busy), 64'd0);
        check("t6_abort_start_mask", mask, (64'd1 << 3) | (64'd1 << 20));

        // Restart after the abort.
        out_ready = 1'b1;
        pulse_start();
        check("t5_restart_mask", mask, 64'd0);
        check("t5_restart_idx", 64'(out_idx), 64'd0);
        run_enum("t5r", 60);
        exp_q = '{20, 3, 50};
        check_list("t5r", exp_q);

`ifdef ARB_SEQ_LIMIT_EN
        clear_prio();
        prio[3] = 3'd2;
        prio[20] = 3'd4;
        prio[50] = 3'd1;
        prio[7] = 3'd6;
        prio[33] = 3'd4;
        out_ready = 1'b1;
        limit = 7'd2;
        pulse_start();
        limit = 7'd0;
        run_enum("t7", 80);
        exp_q = '{7, 33};
        check_list("t7", exp_q);
        limit = 7'd0;
        pulse_start();
        run_enum("t8", 80);
        exp_q = '{7, 33, 20, 3, 50};
        check_list("t8", exp_q);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
